xgriscv_lsu: RTL and testbench
==============================

# xgriscv_lsu

Load/store unit for the xgriscv core. It sits between the pipeline's memory stage and the word-addressed data memory, which reads combinationally and writes one full word at a clock edge. The block turns RISC-V byte, halfword and word loads/stores into whole-word memory accesses. Byte and halfword stores use a read-modify-write sequence. Loads return sign- or zero-extended results, and misaligned or illegal requests are flagged.

## Interface
- `XLEN`, 32, data width
- `ADDR_SIZE`, 32, address width
- `clk`  in  1  clock; all state changes on posedge
- `rstn`  in  1  synchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle, can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- `req_addr`  in  ADDR_SIZE  byte address
- `req_wdata`  in  XLEN  store data, right-aligned
- `req_pc`  in  ADDR_SIZE  pc of the instruction, forwarded to memory
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  XLEN  extended load result; 0 for stores and errors
- `resp_err`  out  1  misaligned or illegal request, valid with resp_valid
- `mem_a`  out  ADDR_SIZE  word address, {addr[31:2],2'b00}
- `mem_wd`  out  XLEN  word to write
- `mem_we`  out  1  write strobe
- `mem_pc`  out  ADDR_SIZE  captured pc
- `mem_rd`  in  XLEN  combinational read data for mem_a

## Operation
- FSM states: IDLE, READ, WRITE, RESP, ERR.
- IDLE, req_ready=1: the handshake (req_valid && req_ready) captures we, funct3, addr, wdata and pc.
- Transitions from IDLE on handshake:
  - illegal or misaligned request → ERR
  - load → READ
  - sw → WRITE
  - sb/sh → READ
- Illegal request: funct3 011/110/111, or a store with funct3 100/101.
- Misaligned request: h/hu with addr[0]=1, or w with addr[1:0]≠0.
- READ, load: sample mem_rd, extract the lane, register resp_rdata → RESP.
  - b/bu: byte lane addr[1:0].
  - h/hu: halfword lane addr[1].
  - b/h sign-extend; bu/hu zero-extend; w unchanged.
- READ, sb/sh: register the merged word → WRITE.
  - Merged word = mem_rd with the byte lane replaced by wdata[7:0], or the halfword lane replaced by wdata[15:0].
- WRITE: mem_we=1 for exactly one cycle.
  - mem_wd = wdata for sw, merged word for sb/sh.
  - Next state RESP.
- RESP: resp_valid=1, resp_err=0 → IDLE.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0, no memory access → IDLE.
- mem_a and mem_pc are driven from captured registers in every state; they are don't-care in IDLE.
- mem_we = (state==WRITE) && rstn, so no write is ever issued while reset is asserted.

## Timing
- Handshake in cycle N. resp_valid arrives at:
  - loads: N+2
  - sw: N+2, with mem_we in N+1
  - sb/sh: N+3, with mem_we in N+2
  - errors: N+1
- req_ready=0 from N+1 until the cycle after resp_valid, when the FSM is back in IDLE. A held req_valid is therefore accepted again at the earliest in resp cycle +1.
- No response backpressure; resp_valid is a single-cycle pulse.
- Reset values while rstn=0 (synchronous):
  - state IDLE
  - req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0
  - mem_we=0, mem_wd=0, mem_a=0, mem_pc=0
  - all capture registers 0
- req_ready=1 in the first cycle after rstn is released.
- Reset in any state aborts the operation: no write, no response. A partially completed sb/sh leaves memory unmodified.
- Memory sees at most one write per request and never writes on loads or errors.

## Structure
- Shared defines file (with XLEN/ADDR_SIZE): funct3 width codes, FSM state encoding.
- Sub-module `lsu_align`, purely combinational:
  - inputs: funct3, addr[1:0], mem_rd, wdata
  - outputs: extracted load value, merged store word, misaligned flag, illegal flag
- The FSM, capture registers and handshake live in the top level.

## Test plan
- lw 0x10, memory word 0x8899AABB: resp_rdata 0x8899AABB at N+2, resp_err 0, mem_we never high.
- lb 0x13 → 0xFFFFFF88; lbu 0x13 → 0x00000088; lh 0x12 → 0xFFFF8899; lhu 0x10 → 0x0000AABB.
- sb data 0x5A to 0x11 over 0x8899AABB: mem_we only in N+2 with mem_a 0x10, mem_wd 0x88995ABB, mem_pc = req_pc; resp_valid at N+3. sh 0x1234 to 0x12 → mem_wd 0x1234AABB.
- lh 0x11 and sw 0x16: resp_valid with resp_err=1 at N+1, resp_rdata 0, mem_we never high. funct3 011 load → same response.
- sh accepted at N, rstn=0 in N+1: no mem_we at any point; req_ready=1 the cycle after rstn rises; memory word unchanged.
- req_valid held high for two back-to-back lw requests: req_ready low N+1..N+2, second handshake at N+3, second resp at N+5.

Source files
------------

// File: rtl/xgriscv_lsu_pkg.sv
// xgriscv_lsu_pkg: shared widths, funct3 width codes and LSU FSM states
package xgriscv_lsu_pkg;
  localparam int XLEN = 32;
  localparam int ADDR_SIZE = 32;
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} state_t;
endpackage

// File: rtl/xgriscv_lsu_align.sv
// lsu_align: lane extraction, store merge and request legality checks
module lsu_align
  import xgriscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] mem_rd,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged,
  output logic            misaligned,
  output logic            illegal
);
  logic [7:0] b;
  logic [15:0] h;
  logic [4:0] sh;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] ins;
  // funct3[0] separates halfword from byte for the merge path
  always_comb begin
    b = mem_rd[{addr, 3'b000} +: 8];
    h = addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    sh = funct3[0] ? {addr[1], 4'b0000} : {addr, 3'b000};
    mask = (funct3[0] ? XLEN'(16'hFFFF) : XLEN'(8'hFF)) << sh;
    ins = (funct3[0] ? XLEN'(wdata[15:0]) : XLEN'(wdata[7:0])) << sh;
    merged = (mem_rd & ~mask) | ins;
    load_data = funct3 == F3_B  ? {{(XLEN-8){b[7]}}, b} :
                funct3 == F3_BU ? XLEN'(b) :
                funct3 == F3_H  ? {{(XLEN-16){h[15]}}, h} :
                funct3 == F3_HU ? XLEN'(h) :
                funct3 == F3_W  ? mem_rd : '0;
    misaligned = (funct3[1:0] == 2'b01 && addr[0]) || (funct3 == F3_W && addr != 2'b00);
    illegal = funct3 == 3'b011 || funct3[2:1] == 2'b11;
  end
endmodule

// File: rtl/xgriscv_lsu.sv
// xgriscv_lsu: byte/half/word load-store unit over a word-addressed memory
module xgriscv_lsu
  import xgriscv_lsu_pkg::*;
#(
  parameter int XLEN = xgriscv_lsu_pkg::XLEN,
  parameter int ADDR_SIZE = xgriscv_lsu_pkg::ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  input  logic [ADDR_SIZE-1:0] req_pc,
  output logic                 resp_valid,
  output logic [XLEN-1:0]      resp_rdata,
  output logic                 resp_err,
  output logic [ADDR_SIZE-1:0] mem_a,
  output logic [XLEN-1:0]      mem_wd,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_pc,
  input  logic [XLEN-1:0]      mem_rd
);
  state_t state, state_n;
  logic we_q;
  logic [2:0] f3_q;
  logic [ADDR_SIZE-1:0] addr_q, pc_q;
  logic [XLEN-1:0] wd_q, rdata_q, load_data, merged;
  logic misaligned, illegal, bad;
  logic idle;
  assign idle = state == IDLE;
  // legality is judged on the live request in IDLE, data paths on captured values
  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (idle ? req_funct3 : f3_q),
    .addr      (idle ? req_addr[1:0] : addr_q[1:0]),
    .mem_rd    (mem_rd),
    .wdata     (wd_q),
    .load_data (load_data),
    .merged    (merged),
    .misaligned(misaligned),
    .illegal   (illegal)
  );
  assign bad = misaligned || illegal || (req_we && req_funct3[2]);
  // state register plus request capture; wd_q later holds the merged word for sb/sh
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      pc_q <= '0;
      wd_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (idle && req_valid) begin
        we_q <= req_we;
        f3_q <= req_funct3;
        addr_q <= req_addr;
        pc_q <= req_pc;
        wd_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state == READ) begin
        if (we_q) wd_q <= merged;
        else rdata_q <= load_data;
      end
    end
  end
  // next-state: loads and sb/sh read first, sw writes directly, errors respond at once
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = !req_valid ? IDLE : bad ? ERR : (req_we && req_funct3 == F3_W) ? WRITE : READ;
      READ:  state_n = we_q ? WRITE : RESP;
      WRITE: state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  assign req_ready = rstn && idle;
  assign resp_valid = rstn && (state == RESP || state == ERR);
  assign resp_err = rstn && state == ERR;
  assign resp_rdata = rstn ? rdata_q : '0;
  assign mem_we = rstn && state == WRITE;
  assign mem_wd = rstn ? wd_q : '0;
  assign mem_a = rstn ? {addr_q[ADDR_SIZE-1:2], 2'b00} : '0;
  assign mem_pc = rstn ? pc_q : '0;
endmodule

// File: tb/tb_xgriscv_lsu.sv
// tb_xgriscv_lsu: directed self-checking bench with a word memory model
module tb_xgriscv_lsu;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_we = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_a, mem_wd, mem_pc, mem_rd;
  logic [31:0] mem [0:63];
  logic poke_en = 1'b0;
  int pidx = 0;
  logic [31:0] pdata = '0;
  int checks = 0;
  int errors = 0;

  xgriscv_lsu dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_we(mem_we), .mem_pc(mem_pc), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  assign mem_rd = mem[mem_a[7:2]];
  // memory write port, with a bench-side preload path
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    else if (poke_en) mem[pidx] <= pdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int i, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1;
    pidx = i;
    pdata = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic run(input string name, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc,
                     input int lat, input logic [31:0] exp_rd, input logic exp_err,
                     input int we_cyc, input logic [31:0] exp_wd);
    @(negedge clk);
    chk({name, "/ready_before"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wd;
    req_pc = pc;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("%s/resp_valid@%0d", name, c), 32'(resp_valid), 32'(c == lat));
      chk($sformatf("%s/mem_we@%0d", name, c), 32'(mem_we), 32'(c == we_cyc));
      chk($sformatf("%s/ready@%0d", name, c), 32'(req_ready), 32'd0);
      if (c == we_cyc) begin
        chk({name, "/mem_a"}, mem_a, {addr[31:2], 2'b00});
        chk({name, "/mem_wd"}, mem_wd, exp_wd);
        chk({name, "/mem_pc"}, mem_pc, pc);
      end
    end
    chk({name, "/rdata"}, resp_rdata, exp_rd);
    chk({name, "/err"}, 32'(resp_err), 32'(exp_err));
    @(negedge clk);
    chk({name, "/ready_after"}, 32'(req_ready), 32'd1);
    chk({name, "/resp_after"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    poke(4, 32'h8899AABB);
    poke(5, 32'h01020304);
    chk("rst/ready", 32'(req_ready), 32'd0);
    chk("rst/resp_valid", 32'(resp_valid), 32'd0);
    chk("rst/resp_err", 32'(resp_err), 32'd0);
    chk("rst/rdata", resp_rdata, 32'd0);
    chk("rst/mem_we", 32'(mem_we), 32'd0);
    chk("rst/mem_a", mem_a, 32'd0);
    chk("rst/mem_wd", mem_wd, 32'd0);
    chk("rst/mem_pc", mem_pc, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("rst/ready_release", 32'(req_ready), 32'd1);

    run("lw",  1'b0, 3'b010, 32'h10, 32'h0, 32'h100, 2, 32'h8899AABB, 1'b0, 0, 32'h0);
    run("lb",  1'b0, 3'b000, 32'h13, 32'h0, 32'h104, 2, 32'hFFFFFF88, 1'b0, 0, 32'h0);
    run("lbu", 1'b0, 3'b100, 32'h13, 32'h0, 32'h108, 2, 32'h00000088, 1'b0, 0, 32'h0);
    run("lh",  1'b0, 3'b001, 32'h12, 32'h0, 32'h10C, 2, 32'hFFFF8899, 1'b0, 0, 32'h0);
    run("lhu", 1'b0, 3'b101, 32'h10, 32'h0, 32'h110, 2, 32'h0000AABB, 1'b0, 0, 32'h0);
    run("lb0", 1'b0, 3'b000, 32'h10, 32'h0, 32'h114, 2, 32'hFFFFFFBB, 1'b0, 0, 32'h0);

    run("sb", 1'b1, 3'b000, 32'h11, 32'h0000005A, 32'h200, 3, 32'h0, 1'b0, 2, 32'h88995ABB);
    chk("sb/mem", mem[4], 32'h88995ABB);
    poke(4, 32'h8899AABB);
    run("sh", 1'b1, 3'b001, 32'h12, 32'h00001234, 32'h204, 3, 32'h0, 1'b0, 2, 32'h1234AABB);
    chk("sh/mem", mem[4], 32'h1234AABB);
    poke(4, 32'h8899AABB);
    run("sw", 1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 32'h208, 2, 32'h0, 1'b0, 1, 32'hDEADBEEF);
    chk("sw/mem", mem[5], 32'hDEADBEEF);

    run("lh_mis",  1'b0, 3'b001, 32'h11, 32'h0, 32'h300, 1, 32'h0, 1'b1, 0, 32'h0);
    run("sw_mis",  1'b1, 3'b010, 32'h16, 32'h55, 32'h304, 1, 32'h0, 1'b1, 0, 32'h0);
    run("ld_f3_3", 1'b0, 3'b011, 32'h10, 32'h0, 32'h308, 1, 32'h0, 1'b1, 0, 32'h0);
    run("st_f3_4", 1'b1, 3'b100, 32'h10, 32'h77, 32'h30C, 1, 32'h0, 1'b1, 0, 32'h0);
    chk("err/mem4", mem[4], 32'h8899AABB);

    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'b001;
    req_addr = 32'h12;
    req_wdata = 32'h0000CAFE;
    req_pc = 32'h400;
    @(negedge clk);
    req_valid = 1'b0;
    rstn = 1'b0;
    #1 chk("abort/mem_we1", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("abort/mem_we2", 32'(mem_we), 32'd0);
    chk("abort/resp", 32'(resp_valid), 32'd0);
    rstn = 1'b1;
    #1 chk("abort/ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("abort/idle_we@%0d", c), 32'(mem_we), 32'd0);
      chk($sformatf("abort/idle_resp@%0d", c), 32'(resp_valid), 32'd0);
    end
    chk("abort/mem", mem[4], 32'h8899AABB);

    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_funct3 = 3'b010;
    req_addr = 32'h10;
    req_pc = 32'h500;
    @(negedge clk);
    chk("b2b/ready1", 32'(req_ready), 32'd0);
    chk("b2b/resp1", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("b2b/ready2", 32'(req_ready), 32'd0);
    chk("b2b/resp2", 32'(resp_valid), 32'd1);
    chk("b2b/rdata2", resp_rdata, 32'h8899AABB);
    @(negedge clk);
    chk("b2b/ready3", 32'(req_ready), 32'd1);
    chk("b2b/resp3", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("b2b/ready4", 32'(req_ready), 32'd0);
    chk("b2b/resp4", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("b2b/resp5", 32'(resp_valid), 32'd1);
    chk("b2b/rdata5", resp_rdata, 32'h8899AABB);
    chk("b2b/we5", 32'(mem_we), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b/ready6", 32'(req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
